// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a 32-bit LFSR stream: acquires lock, then counts mispredicted words.
// Define LFSR_CHECKER_BITERR_EN to count bit errors (popcount) instead of word errors.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 3,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic                     clear_cnt,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned SUM_W = ERR_CNT_WIDTH + 6;

    typedef enum logic [1:0] {
        SEEK,
        VERIFY,
        LOCKED
    } state_t;

    state_t                   state, state_nxt;
    logic [31:0]              expected, expected_nxt;
    logic [3:0]               match_cnt, match_cnt_nxt;
    logic [3:0]               consec_err, consec_err_nxt;
    logic                     err_pulse_nxt;
    logic [ERR_CNT_WIDTH-1:0] err_count_nxt;
    logic                     count_en;
    logic [5:0]               err_inc;
    logic [SUM_W-1:0]         err_sum;
    logic [3:0]               match_inc;
    logic [3:0]               consec_inc;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    assign match_inc  = match_cnt + 4'd1;
    assign consec_inc = consec_err + 4'd1;

`ifdef LFSR_CHECKER_BITERR_EN
    logic [31:0] diff;
    assign diff = in_data ^ expected;
    always_comb begin
        err_inc = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            err_inc = err_inc + 6'(diff[i]);
        end
    end
`else
    assign err_inc = 6'd1;
`endif

    // Widened add so any overflow past the counter width is visible for saturation.
    assign err_sum = {6'd0, err_count} + SUM_W'(err_inc);

    always_comb begin
        state_nxt      = state;
        expected_nxt   = expected;
        match_cnt_nxt  = match_cnt;
        consec_err_nxt = consec_err;
        err_pulse_nxt  = 1'b0;
        count_en       = 1'b0;
        if (in_valid) begin
            case (state)
                SEEK: begin
                    if (in_data != '0) begin
                        expected_nxt  = lfsr_next(in_data);
                        match_cnt_nxt = '0;
                        state_nxt     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == expected) begin
                        expected_nxt  = lfsr_next(in_data);
                        match_cnt_nxt = match_inc;
                        if (match_inc == 4'(LOCK_COUNT)) begin
                            state_nxt      = LOCKED;
                            consec_err_nxt = '0;
                        end
                    end else if (in_data != '0) begin
                        expected_nxt  = lfsr_next(in_data);
                        match_cnt_nxt = '0;
                    end else begin
                        state_nxt = SEEK;
                    end
                end
                LOCKED: begin
                    // Free-run the prediction so a corrupted word never reseeds it.
                    expected_nxt = lfsr_next(expected);
                    if (in_data != expected) begin
                        err_pulse_nxt  = 1'b1;
                        count_en       = 1'b1;
                        consec_err_nxt = consec_inc;
                        if (consec_inc == 4'(UNLOCK_COUNT)) begin
                            state_nxt = SEEK;
                        end
                    end else begin
                        consec_err_nxt = '0;
                    end
                end
                default: state_nxt = SEEK;
            endcase
        end
    end

    always_comb begin
        err_count_nxt = err_count;
        if (clear_cnt) begin
            err_count_nxt = '0;
        end else if (count_en) begin
            if (|err_sum[SUM_W-1:ERR_CNT_WIDTH]) begin
                err_count_nxt = '1;
            end else begin
                err_count_nxt = err_sum[ERR_CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEEK;
            expected   <= '0;
            match_cnt  <= '0;
            consec_err <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nxt;
            expected   <= expected_nxt;
            match_cnt  <= match_cnt_nxt;
            consec_err <= consec_err_nxt;
            err_pulse  <= err_pulse_nxt;
            err_count  <= err_count_nxt;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus random traffic against a window-based model.
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_BITERR_EN
    localparam bit BITMODE = 1'b1;
`else
    localparam bit BITMODE = 1'b0;
`endif
    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        clear_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_locked;
    bit          m_pulse;
    logic [31:0] m_exp;
    int          m_consec;
    int          m_e16;
    int          m_e4;
    logic [31:0] m_hist[$];

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    lfsr_checker #(.LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .ERR_CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear_cnt(clear_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Lock is declared when the last LOCK+1 valid words since losing lock form an unbroken nonzero chain.
    task automatic model_update(input logic v, input logic [31:0] d, input logic c, input logic r);
        int add;
        bit chain;
        m_pulse = 1'b0;
        add = 0;
        if (r) begin
            m_locked = 1'b0; m_exp = '0; m_consec = 0; m_e16 = 0; m_e4 = 0;
            m_hist.delete();
            return;
        end
        if (v) begin
            if (m_locked) begin
                if (d !== m_exp) begin
                    add = BITMODE ? $countones(d ^ m_exp) : 1;
                    m_pulse = 1'b1;
                    m_consec++;
                    if (m_consec >= UNLOCK) begin
                        m_locked = 1'b0;
                        m_hist.delete();
                    end
                end else begin
                    m_consec = 0;
                end
                m_exp = nxt(m_exp);
            end else begin
                m_hist.push_back(d);
                if (m_hist.size() > LOCK + 1) void'(m_hist.pop_front());
                if (m_hist.size() == LOCK + 1 && m_hist[0] != 0) begin
                    chain = 1'b1;
                    for (int i = 0; i < LOCK; i++)
                        if (m_hist[i+1] != nxt(m_hist[i])) chain = 1'b0;
                    if (chain) begin
                        m_locked = 1'b1;
                        m_consec = 0;
                        m_exp = nxt(d);
                        m_hist.delete();
                    end
                end
            end
        end
        if (c) begin
            m_e16 = 0;
            m_e4 = 0;
        end else begin
            m_e16 = (m_e16 + add > 65535) ? 65535 : m_e16 + add;
            m_e4  = (m_e4 + add > 15) ? 15 : m_e4 + add;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic c, input logic r);
        in_valid = v; in_data = d; clear_cnt = c; reset = r;
        @(posedge clk);
        model_update(v, d, c, r);
        @(negedge clk);
    endtask

    task automatic acquire(output logic [31:0] s);
        step(1'b0, '0, 1'b0, 1'b1);
        s = 32'h1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
        end
    endtask

    task automatic test_reset();
        step(1'b1, 32'h1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_pulse: got %0b want 0", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_acquire();
        logic [31:0] s;
        step(1'b0, '0, 1'b0, 1'b1);
        s = 32'h1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
            if (i == 3) begin
                n_checks++; if (locked !== 1'b0) $display("FAIL acq_early_lock: got %0b want 0", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b1) $display("FAIL acq_locked: got %0b want 1", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL acq_count: got %0d want 0", err_count); else n_pass++;
    endtask

    task automatic test_single_error();
        logic [31:0] s;
        acquire(s);
        step(1'b1, 32'h37, 1'b0, 1'b0);
        s = nxt(s);
        n_checks++; if (err_pulse !== 1'b1) $display("FAIL single_pulse: got %0b want 1", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd1) $display("FAIL single_count: got %0d want 1", err_count); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
            n_checks++; if (err_pulse !== 1'b0) $display("FAIL single_pulse_clr: got %0b want 0", err_pulse); else n_pass++;
        end
        n_checks++; if (locked !== 1'b1) $display("FAIL single_locked: got %0b want 1", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd1) $display("FAIL single_count_hold: got %0d want 1", err_count); else n_pass++;
    endtask

    task automatic test_bit_error();
        logic [31:0] s;
        int want;
        logic [31:0] good, bad;
        good = 32'h36;
        bad  = 32'hC9;
        want = BITMODE ? $countones(good ^ bad) : 1;
        acquire(s);
        step(1'b1, bad, 1'b0, 1'b0);
        s = nxt(s);
        step(1'b1, s, 1'b0, 1'b0);
        n_checks++; if (err_count !== 16'(want)) $display("FAIL biterr_count: got %0d want %0d", err_count, want); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL biterr_locked: got %0b want 1", locked); else n_pass++;
    endtask

    task automatic test_loss_of_lock();
        logic [31:0] s;
        acquire(s);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, s ^ 32'h100, 1'b0, 1'b0);
            s = nxt(s);
            n_checks++; if (err_pulse !== 1'b1) $display("FAIL lol_pulse%0d: got %0b want 1", k, err_pulse); else n_pass++;
            if (k == 1) begin
                n_checks++; if (locked !== 1'b1) $display("FAIL lol_still_locked: got %0b want 1", locked); else n_pass++;
            end
        end
        n_checks++; if (locked !== 1'b0) $display("FAIL lol_unlocked: got %0b want 0", locked); else n_pass++;
        n_checks++; if (err_count !== 16'd3) $display("FAIL lol_count: got %0d want 3", err_count); else n_pass++;
        step(1'b1, s, 1'b0, 1'b0);
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL lol_no_count_unlocked: got %0b want 0", err_pulse); else n_pass++;
    endtask

    task automatic test_bubbles();
        logic [31:0] s;
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b0);
        s = 32'h1;
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < 1 + int'($urandom_range(0, 2)); g++) begin
                step(1'b0, $urandom, 1'b0, 1'b0);
                n_checks++; if (locked !== 1'b0) $display("FAIL bubble_locked: got %0b want 0", locked); else n_pass++;
            end
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
            n_checks++;
            if (locked !== (i == 4)) $display("FAIL bubble_lock_word%0d: got %0b want %0b", i, locked, i == 4);
            else n_pass++;
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b1) $display("FAIL bubble_hold: got %0b want 1", locked); else n_pass++;
    endtask

    task automatic test_saturation_clear();
        logic [31:0] s;
        acquire(s);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, s ^ 32'h1, 1'b0, 1'b0);
            s = nxt(s);
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
        end
        n_checks++; if (err_count4 !== 4'd15) $display("FAIL sat_count4: got %0d want 15", err_count4); else n_pass++;
        n_checks++; if (err_count !== 16'd20) $display("FAIL sat_count16: got %0d want 20", err_count); else n_pass++;
        n_checks++; if (locked4 !== 1'b1) $display("FAIL sat_locked: got %0b want 1", locked4); else n_pass++;
        step(1'b1, s ^ 32'h1, 1'b1, 1'b0);
        s = nxt(s);
        n_checks++; if (err_count !== 16'd0) $display("FAIL clear_count16: got %0d want 0", err_count); else n_pass++;
        n_checks++; if (err_count4 !== 4'd0) $display("FAIL clear_count4: got %0d want 0", err_count4); else n_pass++;
        n_checks++; if (err_pulse !== 1'b1) $display("FAIL clear_pulse: got %0b want 1", err_pulse); else n_pass++;
        n_checks++; if (locked !== 1'b1) $display("FAIL clear_fsm: got %0b want 1", locked); else n_pass++;
    endtask

    task automatic test_reset_mid_lock();
        logic [31:0] s;
        acquire(s);
        step(1'b1, s ^ 32'h1, 1'b0, 1'b0);
        s = nxt(s);
        step(1'b1, s ^ 32'h1, 1'b0, 1'b1);
        s = nxt(s);
        n_checks++; if (locked !== 1'b0) $display("FAIL rst_lock_locked: got %0b want 0", locked); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL rst_lock_pulse: got %0b want 0", err_pulse); else n_pass++;
        n_checks++; if (err_count !== 16'd0) $display("FAIL rst_lock_count: got %0d want 0", err_count); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s, 1'b0, 1'b0);
            s = nxt(s);
            n_checks++;
            if (locked !== (i == 4)) $display("FAIL rst_reacq_word%0d: got %0b want %0b", i, locked, i == 4);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] g, d;
        logic v, c, r;
        step(1'b0, '0, 1'b0, 1'b1);
        g = $urandom | 32'h1;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 31) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if (v) begin
                d = g;
                g = nxt(g);
                case ($urandom_range(0, 19))
                    0: d = d ^ (32'h1 << $urandom_range(0, 31));
                    1: d = $urandom;
                    2: d = '0;
                    3: g = $urandom | 32'h1;
                    default: ;
                endcase
            end
            step(v, d, c, r);
            n_checks++; if (locked !== m_locked) $display("FAIL rnd_locked@%0d: got %0b want %0b", n, locked, m_locked); else n_pass++;
            n_checks++; if (err_pulse !== m_pulse) $display("FAIL rnd_pulse@%0d: got %0b want %0b", n, err_pulse, m_pulse); else n_pass++;
            n_checks++; if (err_count !== 16'(m_e16)) $display("FAIL rnd_count@%0d: got %0d want %0d", n, err_count, m_e16); else n_pass++;
            n_checks++; if (err_count4 !== 4'(m_e4)) $display("FAIL rnd_count4@%0d: got %0d want %0d", n, err_count4, m_e4); else n_pass++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_acquire();
        test_single_error();
        test_bit_error();
        test_loss_of_lock();
        test_bubbles();
        test_saturation_clear();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
